// File: rtl/apb_requester.sv
// APB4 requester: converts single-beat valid/ready commands into APB SETUP/ACCESS
// transfers and returns read data, slave error and timeout status on a response port.
module apb_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    // command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]                cmd_prot,
    input  logic                      cmd_nse,
    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    // APB requester port
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      pnse,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwakeup,
    input  logic                      pready,
    input  logic                      pslverr,
    input  logic [DATA_WIDTH-1:0]     prdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abort fires on the last permitted ACCESS cycle, i.e. after TIMEOUT_CYCLES-1 stalls.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                  state_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    cnt_d;
    logic                    accept;
    logic                    timeout_hit;

    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [2:0]              pprot_q;
    logic                    pnse_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_WIDTH-1:0]   pstrb_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwakeup_q;

    // NOTE: always_comb gives each output a value on every path, so no latch can form.
    always_comb begin
        accept      = (state_q == IDLE) && cmd_valid && cmd_ready_q;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
        cnt_d       = cnt_q + CNT_WIDTH'(1);
    end

    // NOTE: sequential state uses <= only, so every register sees pre-edge values.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pnse_q        <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwakeup_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        paddr_q     <= cmd_addr;
                        pprot_q     <= cmd_prot;
                        pnse_q      <= cmd_nse;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_write ? cmd_wdata : '0;
                        pstrb_q     <= cmd_write ? cmd_strb : '0;
                        psel_q      <= 1'b1;
                        pwakeup_q   <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        pwakeup_q     <= 1'b0;
                        state_q       <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        pwakeup_q     <= 1'b0;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign pprot       = pprot_q;
    assign pnse        = pnse_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwakeup     = pwakeup_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed vector table, hand-written
// multi-cycle sequences and randomized transfers against a transfer-level model.
module tb_apb_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          cmd_nse = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          pnse;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          psel;
    logic          penable;
    logic          pwakeup;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [DW-1:0] prdata = '0;

    apb_requester #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .cmd_prot   (cmd_prot),
        .cmd_nse    (cmd_nse),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pprot      (pprot),
        .pnse       (pnse),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .psel       (psel),
        .penable    (penable),
        .pwakeup    (pwakeup),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;

    // One command plus the completer's behaviour for it: pready rises on ACCESS cycle waits+1.
    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        logic          nse;
        logic [7:0]    waits;
        logic [DW-1:0] prdata;
        logic          slverr;
    } txn_t;

    typedef struct packed {
        txn_t          t;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
        int            exp_pen;
    } vec_t;

    task automatic check(input string tag, input string what, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, what, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] s, input logic [2:0] p, input logic n,
                                input logic [7:0] wt, input logic [DW-1:0] rd, input logic e);
        txn_t t;
        t.write = w;  t.addr = a;  t.wdata = wd; t.strb = s;  t.prot = p;
        t.nse = n;    t.waits = wt; t.prdata = rd; t.slverr = e;
        return t;
    endfunction

    // Transfer-level model: the completer answers within the budget or the transfer is aborted.
    function automatic void model(input txn_t t, output logic [DW-1:0] rdata, output logic err,
                                  output logic to, output int pen);
        if (int'(t.waits) < TO) begin
            pen   = int'(t.waits) + 1;
            to    = 1'b0;
            err   = t.slverr;
            rdata = t.write ? '0 : t.prdata;
        end else begin
            pen   = TO;
            to    = 1'b1;
            err   = 1'b1;
            rdata = '0;
        end
    endfunction

    function automatic txn_t rand_txn();
        int r;
        logic [7:0] wt;
        r = $urandom_range(0, 9);
        if (r < 6)       wt = 8'($urandom_range(0, 4));
        else if (r == 6) wt = 8'd15;
        else if (r == 7) wt = 8'd16;
        else             wt = 8'($urandom_range(17, 40));
        return mk(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom), 1'($urandom),
                  wt, $urandom, 1'($urandom));
    endfunction

    task automatic drive_cmd(input txn_t t);
        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_strb  = t.strb;
        cmd_prot  = t.prot;
        cmd_nse   = t.nse;
    endtask

    task automatic wait_accept(input string tag);
        bit rdy;
        int guard = 0;
        do begin
            rdy = cmd_ready;
            @(posedge pclk); #1;
            guard++;
        end while (!rdy && guard < 20);
        check(tag, "accepted", 64'(rdy), 64'd1);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "ctl", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwakeup,
                           pwrite, pnse}, '0);
        check(tag, "prot_strb", {pprot, pstrb}, '0);
        check(tag, "paddr", 64'(paddr), '0);
        check(tag, "pwdata", 64'(pwdata), '0);
        check(tag, "rsp_rdata", 64'(rsp_rdata), '0);
    endtask

    // Full transfer: accept, SETUP, ACCESS with modelled completer, RESP held rsp_delay cycles.
    // With pend set, the next command is already presented while the response is stalled.
    task automatic run_txn(input string tag, input txn_t t, input logic [DW-1:0] er,
                           input logic ee, input logic eto, input int epen,
                           input int rsp_delay, input bit pend, input txn_t nxt);
        int pen;
        drive_cmd(t);
        wait_accept(tag);
        check(tag, "setup_ctl", {psel, penable, pwakeup, cmd_ready, rsp_valid}, 64'b10100);
        check(tag, "paddr", 64'(paddr), 64'(t.addr));
        check(tag, "pwdata", 64'(pwdata), t.write ? 64'(t.wdata) : 64'd0);
        check(tag, "pwrite_strb_prot_nse", {pwrite, pstrb, pprot, pnse},
              {t.write, (t.write ? t.strb : 4'h0), t.prot, t.nse});
        @(posedge pclk); #1;
        pen = 0;
        while (penable && pen < 40) begin
            pen++;
            check(tag, "access_ctl", {psel, penable, pwakeup, cmd_ready, rsp_valid}, 64'b11100);
            check(tag, "paddr_hold", 64'(paddr), 64'(t.addr));
            pready  = (pen == int'(t.waits) + 1);
            prdata  = pready ? t.prdata : $urandom;
            pslverr = pready ? t.slverr : 1'($urandom);
            @(posedge pclk); #1;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        check(tag, "penable_cycles", 64'(pen), 64'(epen));
        if (pend) drive_cmd(nxt);
        for (int i = 0; i <= rsp_delay; i++) begin
            check(tag, "resp_ctl", {psel, penable, pwakeup, cmd_ready, rsp_valid}, 64'b00001);
            check(tag, "rsp_rdata", 64'(rsp_rdata), 64'(er));
            check(tag, "rsp_err_timeout", {rsp_err, rsp_timeout}, {ee, eto});
            if (i == rsp_delay) rsp_ready = 1'b1;
            @(posedge pclk); #1;
        end
        rsp_ready = 1'b0;
        check(tag, "idle_ctl", {rsp_valid, cmd_ready, psel}, 64'b010);
    endtask

    vec_t vt[7];
    txn_t rtx[41];
    txn_t none;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] er;
        logic ee, eto;
        int ep, first_acc;
        txn_t a, b;

        none = mk(1'b0, '0, '0, '0, '0, 1'b0, 8'd0, '0, 1'b0);

        vt[0].t = mk(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'd0, 1'b0, 8'd0, 32'hDEAD_BEEF, 1'b0);
        vt[0].exp_rdata = 32'h0;         vt[0].exp_err = 1'b0; vt[0].exp_to = 1'b0; vt[0].exp_pen = 1;
        vt[1].t = mk(1'b0, 32'h20, 32'h1234_5678, 4'hF, 3'd2, 1'b0, 8'd3, 32'hFFFF_FFFF, 1'b0);
        vt[1].exp_rdata = 32'hFFFF_FFFF; vt[1].exp_err = 1'b0; vt[1].exp_to = 1'b0; vt[1].exp_pen = 4;
        vt[2].t = mk(1'b0, 32'h24, 32'h0, 4'h3, 3'd1, 1'b1, 8'd1, 32'h0BAD_F00D, 1'b1);
        vt[2].exp_rdata = 32'h0BAD_F00D; vt[2].exp_err = 1'b1; vt[2].exp_to = 1'b0; vt[2].exp_pen = 2;
        vt[3].t = mk(1'b1, 32'h30, 32'hCAFE_0030, 4'h5, 3'd5, 1'b1, 8'd2, 32'h7777_7777, 1'b1);
        vt[3].exp_rdata = 32'h0;         vt[3].exp_err = 1'b1; vt[3].exp_to = 1'b0; vt[3].exp_pen = 3;
        vt[4].t = mk(1'b0, 32'h40, 32'h0, 4'h0, 3'd0, 1'b0, 8'd100, 32'h1111_2222, 1'b0);
        vt[4].exp_rdata = 32'h0;         vt[4].exp_err = 1'b1; vt[4].exp_to = 1'b1; vt[4].exp_pen = 16;
        vt[5].t = mk(1'b0, 32'h44, 32'h0, 4'hF, 3'd7, 1'b0, 8'd15, 32'h1357_9BDF, 1'b0);
        vt[5].exp_rdata = 32'h1357_9BDF; vt[5].exp_err = 1'b0; vt[5].exp_to = 1'b0; vt[5].exp_pen = 16;
        vt[6].t = mk(1'b1, 32'h48, 32'h5555_AAAA, 4'h9, 3'd3, 1'b1, 8'd100, 32'h0, 1'b0);
        vt[6].exp_rdata = 32'h0;         vt[6].exp_err = 1'b1; vt[6].exp_to = 1'b1; vt[6].exp_pen = 16;

        // reset state
        repeat (2) @(posedge pclk);
        #1;
        check_all_zero("reset");
        preset = 1'b0;

        // directed vector table
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vt[i].t, vt[i].exp_rdata, vt[i].exp_err,
                    vt[i].exp_to, vt[i].exp_pen, i % 3, 1'b0, none);
        end

        // response back-pressure for 5 cycles with a new command waiting
        a = mk(1'b0, 32'h50, 32'h0, 4'h0, 3'd0, 1'b0, 8'd0, 32'hABCD_0050, 1'b0);
        b = mk(1'b1, 32'h54, 32'h0000_0054, 4'hC, 3'd4, 1'b1, 8'd1, 32'h0, 1'b0);
        run_txn("stall", a, 32'hABCD_0050, 1'b0, 1'b0, 1, 5, 1'b1, b);
        run_txn("stall_next", b, 32'h0, 1'b0, 1'b0, 2, 0, 1'b0, none);

        // minimum spacing between accepts with a zero-wait completer
        a = mk(1'b1, 32'h60, 32'h0000_0060, 4'hF, 3'd0, 1'b0, 8'd0, 32'h0, 1'b0);
        b = mk(1'b0, 32'h64, 32'h0, 4'hF, 3'd0, 1'b0, 8'd0, 32'h6464_6464, 1'b0);
        run_txn("spacing_a", a, 32'h0, 1'b0, 1'b0, 1, 0, 1'b1, b);
        first_acc = acc_cyc;
        run_txn("spacing_b", b, 32'h6464_6464, 1'b0, 1'b0, 1, 0, 1'b0, none);
        check("spacing", "accept_gap", 64'(acc_cyc - first_acc), 64'd4);

        // reset asserted during ACCESS
        a = mk(1'b1, 32'h70, 32'hFACE_0070, 4'hF, 3'd6, 1'b1, 8'd50, 32'h0, 1'b0);
        drive_cmd(a);
        wait_accept("rst_mid");
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        check("rst_mid", "in_access", {psel, penable}, 64'b11);
        preset = 1'b1;
        @(posedge pclk); #1;
        check_all_zero("rst_mid");
        preset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            check("rst_after", "no_rsp_no_psel", {rsp_valid, psel, penable}, 64'b000);
        end
        b = mk(1'b0, 32'h74, 32'h0, 4'h0, 3'd0, 1'b0, 8'd2, 32'h7474_0074, 1'b0);
        run_txn("rst_recover", b, 32'h7474_0074, 1'b0, 1'b0, 3, 1, 1'b0, none);

        // randomized transfers against the model
        for (int i = 0; i < 41; i++) rtx[i] = rand_txn();
        for (int i = 0; i < 40; i++) begin
            model(rtx[i], er, ee, eto, ep);
            run_txn($sformatf("rnd%0d", i), rtx[i], er, ee, eto, ep,
                    $urandom_range(0, 3), 1'($urandom), rtx[i+1]);
        end
        cmd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
